eth_pkt_builder: RTL and testbench

ETH_PKT_BUILDER -- requirements
Module: eth_pkt_builder

---
 rtl/eth_pkt_builder.sv | 113 +++++++++++
 tb/tb_eth_pkt_builder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pkt_builder.sv
// Ethernet payload builder: forwards user bytes into the transmitter's payload FIFO,
// zero-pads short payloads, truncates long ones, then hands the frame off and waits for Tx_Done.
module eth_pkt_builder #(
  parameter int pMIN_LEN = 46,
  parameter int pMAX_LEN = 1500
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  User_Data,
  input  logic        User_Valid,
  input  logic        User_Last,
  output logic        User_Ready,
  input  logic        Tx_Done,
  output logic [7:0]  Eth_Byte,
  output logic        Eth_Byte_Valid,
  output logic        Eth_Pkt_Rdy,
  output logic [10:0] Pkt_Len,
  output logic        Trunc_Err
);

  localparam logic [10:0] MIN_C = 11'(pMIN_LEN);
  localparam logic [10:0] MAX_C = 11'(pMAX_LEN);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_DROP,
    S_PAD,
    S_NOTIFY,
    S_WAIT_DONE
  } state_t;

  state_t      state_q;
  logic [10:0] cnt_q;
  logic [10:0] cnt_d;
  logic        en_q;
  logic [7:0]  byte_q;
  logic        vld_q;
  logic        rdy_q;
  logic [10:0] len_q;
  logic        trunc_q;
  logic        xfer;

  // en_q holds User_Ready low until the first clock edge after reset releases.
  assign User_Ready = en_q && ((state_q == S_COLLECT) || (state_q == S_DROP));
  assign xfer       = User_Valid && User_Ready;
  assign cnt_d      = cnt_q + 11'd1;

  assign Eth_Byte       = byte_q;
  assign Eth_Byte_Valid = vld_q;
  assign Eth_Pkt_Rdy    = rdy_q;
  assign Pkt_Len        = len_q;
  assign Trunc_Err      = trunc_q;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_COLLECT;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      byte_q  <= '0;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      len_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      en_q    <= 1'b1;
      vld_q   <= 1'b0;
      rdy_q   <= 1'b0;
      trunc_q <= 1'b0;
      case (state_q)
        S_COLLECT: begin
          if (xfer) begin
            byte_q <= User_Data;
            vld_q  <= 1'b1;
            cnt_q  <= cnt_d;
            // A final byte takes priority over the length cap, so exactly pMAX_LEN is not a truncation.
            if (User_Last) begin
              state_q <= (cnt_d < MIN_C) ? S_PAD : S_NOTIFY;
            end else if (cnt_d == MAX_C) begin
              state_q <= S_DROP;
            end
          end
        end
        S_DROP: begin
          if (xfer && User_Last) begin
            trunc_q <= 1'b1;
            state_q <= S_NOTIFY;
          end
        end
        S_PAD: begin
          byte_q <= 8'h00;
          vld_q  <= 1'b1;
          cnt_q  <= cnt_d;
          if (cnt_d == MIN_C) begin
            state_q <= S_NOTIFY;
          end
        end
        S_NOTIFY: begin
          rdy_q   <= 1'b1;
          len_q   <= cnt_q;
          cnt_q   <= '0;
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (Tx_Done) begin
            state_q <= S_COLLECT;
          end
        end
        default: state_q <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_pkt_builder.sv
// Bench for eth_pkt_builder: per-cycle comparison against a packet-level timing model,
// plus literal expectations per directed scenario.
module tb_eth_pkt_builder;

  localparam int MIN = 46;
  localparam int MAX = 1500;

  logic        Clk;
  logic        Rst;
  logic [7:0]  User_Data;
  logic        User_Valid;
  logic        User_Last;
  logic        User_Ready;
  logic        Tx_Done;
  logic [7:0]  Eth_Byte;
  logic        Eth_Byte_Valid;
  logic        Eth_Pkt_Rdy;
  logic [10:0] Pkt_Len;
  logic        Trunc_Err;

  eth_pkt_builder #(.pMIN_LEN(MIN), .pMAX_LEN(MAX)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .User_Data(User_Data),
    .User_Valid(User_Valid),
    .User_Last(User_Last),
    .User_Ready(User_Ready),
    .Tx_Done(Tx_Done),
    .Eth_Byte(Eth_Byte),
    .Eth_Byte_Valid(Eth_Byte_Valid),
    .Eth_Pkt_Rdy(Eth_Pkt_Rdy),
    .Pkt_Len(Pkt_Len),
    .Trunc_Err(Trunc_Err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Packet-level model: events are scheduled by cycle number when a payload ends.
  int          cyc;
  int          in_cnt;
  logic        fwd_pend;
  logic [7:0]  fwd_byte;
  int          pad_s, pad_e, rdy_c, trunc_c;
  int          next_len, exp_len;
  logic        busy;
  int          strobe_cnt, rdy_cnt, trunc_cnt;
  logic [7:0]  obs [0:2047];

  task automatic model_reset();
    cyc = 0; in_cnt = 0; fwd_pend = 1'b0; fwd_byte = '0;
    pad_s = -1; pad_e = -2; rdy_c = -1; trunc_c = -1;
    next_len = 0; exp_len = 0; busy = 1'b0;
  endtask

  initial begin
    model_reset();
    strobe_cnt = 0; rdy_cnt = 0; trunc_cnt = 0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        model_reset();
      end else begin
        logic exp_vld;
        int   n;
        cyc++;
        exp_vld = fwd_pend || (cyc >= pad_s && cyc <= pad_e);
        chk("byte_valid", 32'(Eth_Byte_Valid), 32'(exp_vld));
        if (exp_vld && Eth_Byte_Valid)
          chk("byte_data", 32'(Eth_Byte), fwd_pend ? 32'(fwd_byte) : 32'h0);
        if (cyc == rdy_c) exp_len = next_len;
        chk("pkt_rdy", 32'(Eth_Pkt_Rdy), 32'(cyc == rdy_c));
        chk("trunc_err", 32'(Trunc_Err), 32'(cyc == trunc_c));
        chk("pkt_len", 32'(Pkt_Len), 32'(exp_len));
        chk("user_ready", 32'(User_Ready), 32'(!busy));
        if (Eth_Byte_Valid) begin
          if (strobe_cnt < 2048) obs[strobe_cnt] = Eth_Byte;
          strobe_cnt++;
        end
        if (Eth_Pkt_Rdy) rdy_cnt++;
        if (Trunc_Err) trunc_cnt++;
        // Work out what the coming rising edge does.
        fwd_pend = 1'b0;
        if (User_Valid && User_Ready) begin
          in_cnt++;
          if (in_cnt <= MAX) begin
            fwd_pend = 1'b1;
            fwd_byte = User_Data;
          end
          if (User_Last) begin
            busy = 1'b1;
            n = in_cnt;
            in_cnt = 0;
            if (n > MAX) begin
              trunc_c = cyc + 1; rdy_c = cyc + 2; next_len = MAX;
            end else if (n < MIN) begin
              pad_s = cyc + 2; pad_e = cyc + 1 + (MIN - n); rdy_c = pad_e + 1; next_len = MIN;
            end else begin
              rdy_c = cyc + 2; next_len = n;
            end
          end
        end
        if (Tx_Done && busy && cyc >= rdy_c) busy = 1'b0;
      end
    end
  end

  task automatic send_pkt(input int n, input int gapmax, input int base, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int gap;
      int t;
      gap = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
      for (int g = 0; g < gap; g++) begin
        User_Valid = 1'b0;
        User_Last  = 1'($urandom_range(0, 1));
        User_Data  = 8'($urandom);
        @(posedge Clk); #1;
      end
      User_Valid = 1'b1;
      User_Data  = 8'(base + i);
      User_Last  = with_last && (i == n - 1);
      t = 0;
      @(negedge Clk);
      while (!User_Ready && t < 5000) begin
        t++;
        @(negedge Clk);
      end
      if (t >= 5000) begin
        chk("send_timeout", 32'd1, 32'd0);
        User_Valid = 1'b0; User_Last = 1'b0;
        return;
      end
      @(posedge Clk); #1;
      User_Valid = 1'b0;
      User_Last  = 1'b0;
    end
  endtask

  task automatic wait_rdy();
    int t = 0;
    @(negedge Clk);
    while (!Eth_Pkt_Rdy && t < 4000) begin
      t++;
      @(negedge Clk);
    end
    if (t >= 4000) chk("rdy_timeout", 32'd1, 32'd0);
    #1;
  endtask

  task automatic pulse_tx();
    @(posedge Clk); #1;
    Tx_Done = 1'b1;
    @(posedge Clk); #1;
    Tx_Done = 1'b0;
  endtask

  task automatic clr_counts();
    strobe_cnt = 0; rdy_cnt = 0; trunc_cnt = 0;
  endtask

  initial begin
    Rst = 1'b1; User_Data = '0; User_Valid = 1'b0; User_Last = 1'b0; Tx_Done = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    chk("rst_byte", 32'(Eth_Byte), 32'h0);
    chk("rst_vld", 32'(Eth_Byte_Valid), 32'h0);
    chk("rst_rdy", 32'(Eth_Pkt_Rdy), 32'h0);
    chk("rst_len", 32'(Pkt_Len), 32'h0);
    chk("rst_trunc", 32'(Trunc_Err), 32'h0);
    Rst = 1'b0;
    @(posedge Clk); #1;
    chk("ready_after_rst", 32'(User_Ready), 32'h1);

    // 60-byte payload, no padding
    clr_counts();
    send_pkt(60, 0, 1, 1'b1);
    wait_rdy();
    chk("p60_strobes", 32'(strobe_cnt), 32'd60);
    chk("p60_len", 32'(Pkt_Len), 32'd60);
    chk("p60_first", 32'(obs[0]), 32'h01);
    chk("p60_last", 32'(obs[59]), 32'h3C);
    chk("p60_trunc", 32'(trunc_cnt), 32'd0);
    chk("p60_rdy_cnt", 32'(rdy_cnt), 32'd1);
    pulse_tx();

    // 10-byte payload padded to 46; a Tx_Done during padding is ignored
    clr_counts();
    send_pkt(10, 0, 1, 1'b1);
    pulse_tx();
    wait_rdy();
    chk("p10_strobes", 32'(strobe_cnt), 32'd46);
    chk("p10_len", 32'(Pkt_Len), 32'd46);
    chk("p10_b9", 32'(obs[9]), 32'h0A);
    chk("p10_pad0", 32'(obs[10]), 32'h00);
    chk("p10_pad45", 32'(obs[45]), 32'h00);
    pulse_tx();

    // single byte
    clr_counts();
    send_pkt(1, 0, 8'h5A, 1'b1);
    wait_rdy();
    chk("p1_len", 32'(Pkt_Len), 32'd46);
    chk("p1_b0", 32'(obs[0]), 32'h5A);
    pulse_tx();

    // 1600 bytes: truncated to 1500
    clr_counts();
    send_pkt(1600, 0, 1, 1'b1);
    wait_rdy();
    chk("p1600_strobes", 32'(strobe_cnt), 32'd1500);
    chk("p1600_trunc", 32'(trunc_cnt), 32'd1);
    chk("p1600_len", 32'(Pkt_Len), 32'd1500);
    chk("p1600_lastbyte", 32'(obs[1499]), 32'hDC);
    pulse_tx();

    // exactly 1500 bytes: no truncation
    clr_counts();
    send_pkt(1500, 0, 3, 1'b1);
    wait_rdy();
    chk("p1500_strobes", 32'(strobe_cnt), 32'd1500);
    chk("p1500_trunc", 32'(trunc_cnt), 32'd0);
    chk("p1500_len", 32'(Pkt_Len), 32'd1500);
    pulse_tx();

    // Tx_Done while collecting does nothing; back-to-back packet stalls until Tx_Done
    pulse_tx();
    clr_counts();
    fork
      send_pkt(50, 0, 20, 1'b1);
      begin repeat (10) @(posedge Clk); #1; Tx_Done = 1'b1; @(posedge Clk); #1; Tx_Done = 1'b0; end
    join
    wait_rdy();
    chk("p50_len", 32'(Pkt_Len), 32'd50);
    @(posedge Clk); #1;
    chk("stall_ready", 32'(User_Ready), 32'h0);
    clr_counts();
    fork
      send_pkt(48, 0, 100, 1'b1);
      begin repeat (5) @(posedge Clk); #1; Tx_Done = 1'b1; @(posedge Clk); #1; Tx_Done = 1'b0; end
    join
    wait_rdy();
    chk("p48_len", 32'(Pkt_Len), 32'd48);
    chk("p48_strobes", 32'(strobe_cnt), 32'd48);
    chk("p48_first", 32'(obs[0]), 32'd100);
    pulse_tx();

    // reset in the middle of a packet
    send_pkt(20, 0, 1, 1'b0);
    @(posedge Clk); #3;
    Rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(User_Ready), 32'h0);
    chk("mid_rst_vld", 32'(Eth_Byte_Valid), 32'h0);
    chk("mid_rst_byte", 32'(Eth_Byte), 32'h0);
    chk("mid_rst_len", 32'(Pkt_Len), 32'h0);
    chk("mid_rst_rdy", 32'(Eth_Pkt_Rdy), 32'h0);
    chk("mid_rst_trunc", 32'(Trunc_Err), 32'h0);
    @(negedge Clk); #1;
    Rst = 1'b0;
    @(posedge Clk); #1;
    clr_counts();
    send_pkt(46, 0, 50, 1'b1);
    wait_rdy();
    chk("p46_len", 32'(Pkt_Len), 32'd46);
    chk("p46_strobes", 32'(strobe_cnt), 32'd46);
    pulse_tx();

    // 100 bytes with random gaps
    clr_counts();
    send_pkt(100, 3, 7, 1'b1);
    wait_rdy();
    chk("p100_strobes", 32'(strobe_cnt), 32'd100);
    chk("p100_len", 32'(Pkt_Len), 32'd100);
    chk("p100_last", 32'(obs[99]), 32'd106);
    pulse_tx();

    repeat (5) @(posedge Clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
